imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter_pkg.sv | 24 ++
 rtl/imem_starve_ctr.sv | 38 +++
 rtl/imem_arbiter.sv | 117 +++++++++++
 tb/tb_imem_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arbiter_pkg.sv
// rtl/imem_arbiter_pkg.sv - shared constants, types and helpers for the instruction memory arbiter
package imem_arbiter_pkg;

    localparam int IW         = 32;
    localparam int AW_DEFAULT = 16;

    localparam logic [IW-1:0] NOOP_INSTR = 32'h0000_0000;

    // Which requester owns the memory port in the current cycle
    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_FETCH = 2'd1,
        SRC_LOAD  = 2'd2
    } src_e;

    // True when the word index has bits set above the implemented memory width
    function automatic logic addr_out_of_range(input logic [31:0] addr, input int aw);
        if (aw >= 32) begin
            return 1'b0;
        end
        return (addr >> aw) != 32'd0;
    endfunction

endpackage

// File: rtl/imem_starve_ctr.sv
// rtl/imem_starve_ctr.sv - saturating count of cycles a load has waited behind fetches
module imem_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load_req,
    input  logic load_gnt,
    output logic starved
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count waiting cycles, clear when the load finally gets the port, hold at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (load_gnt) begin
            cnt_d = '0;
        end else if (load_req && (cnt_q != CW'(STARVE_MAX))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starved = (cnt_q == CW'(STARVE_MAX));

endmodule

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - single-port instruction memory arbiter between fetch and program loader
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int AW         = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_req,
    input  logic [31:0]   fetch_addr,
    output logic          fetch_gnt,
    output logic          fetch_valid,
    output logic [IW-1:0] fetch_instr,
    input  logic          load_req,
    input  logic [31:0]   load_addr,
    input  logic [IW-1:0] load_data,
    output logic          load_gnt,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [IW-1:0] mem_wdata,
    input  logic [IW-1:0] mem_rdata,
    output logic          addr_fault
);

    logic starved;
    logic fetch_bad;
    logic load_bad;
    logic load_wins;
    src_e src;

    logic rsp_valid_q,  rsp_valid_d;
    logic rsp_noop_q,   rsp_noop_d;
    logic addr_fault_q, addr_fault_d;

    imem_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk      (clk),
        .rst      (rst),
        .load_req (load_req),
        .load_gnt (load_gnt),
        .starved  (starved)
    );

    // Arbitration: fetch has priority unless the load has waited STARVE_MAX cycles
    always_comb begin
        fetch_bad = addr_out_of_range(fetch_addr, AW);
        load_bad  = addr_out_of_range(load_addr, AW);
        load_wins = load_req && (!fetch_req || starved);
        load_gnt  = !rst && load_wins;
        fetch_gnt = !rst && fetch_req && !load_wins;
        src       = SRC_NONE;
        if (load_gnt && !load_bad) begin
            src = SRC_LOAD;
        end else if (fetch_gnt && !fetch_bad) begin
            src = SRC_FETCH;
        end
    end

    // Drive the memory port in the grant cycle; out-of-range accesses never reach memory
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (src)
            SRC_LOAD: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = load_addr[AW-1:0];
                mem_wdata = load_data;
            end
            SRC_FETCH: begin
                mem_en    = 1'b1;
                mem_addr  = fetch_addr[AW-1:0];
            end
            default: begin
                mem_en    = 1'b0;
            end
        endcase
    end

    // Next-state for the response pipe stage and the sticky fault flag
    always_comb begin
        rsp_valid_d  = fetch_gnt;
        rsp_noop_d   = fetch_gnt && fetch_bad;
        addr_fault_d = addr_fault_q
                     | (fetch_gnt && fetch_bad)
                     | (load_gnt && load_bad);
    end

    // Response and fault registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_noop_q   <= 1'b0;
            addr_fault_q <= 1'b0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_noop_q   <= rsp_noop_d;
            addr_fault_q <= addr_fault_d;
        end
    end

    // Outputs are forced quiet while reset is held so an in-flight read is discarded
    always_comb begin
        fetch_valid = rsp_valid_q && !rst;
        addr_fault  = addr_fault_q && !rst;
        fetch_instr = NOOP_INSTR;
        if (fetch_valid && !rsp_noop_q) begin
            fetch_instr = mem_rdata;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - scoreboard bench for imem_arbiter with reference model and random traffic
module tb_imem_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int AW         = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req;
    logic [31:0]   fetch_addr;
    logic          fetch_gnt;
    logic          fetch_valid;
    logic [31:0]   fetch_instr;
    logic          load_req;
    logic [31:0]   load_addr;
    logic [31:0]   load_data;
    logic          load_gnt;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'h0;
    logic          addr_fault;

    always #5 clk = ~clk;

    imem_arbiter #(
        .STARVE_MAX (STARVE_MAX),
        .AW         (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_gnt   (fetch_gnt),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .load_req    (load_req),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_gnt    (load_gnt),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .addr_fault  (addr_fault)
    );

    function automatic logic [31:0] init_word(input logic [15:0] a);
        return {a, ~a} ^ 32'h5A5A_0F0F;
    endfunction

    // External synchronous memory: registered read, write lands at the clock edge
    logic [31:0] bmem [0:65535];
    bit          bval [0:65535];
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            bmem[mem_addr] <= mem_wdata;
            bval[mem_addr] <= 1'b1;
        end else if (mem_en) begin
            mem_rdata <= bval[mem_addr] ? bmem[mem_addr] : init_word(mem_addr);
        end
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int waits  = 0;
    bit fault_m = 1'b0;
    logic [31:0] ref_mem [int unsigned];

    typedef struct {
        int          due;
        logic [31:0] instr;
    } rsp_t;
    rsp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [15:0] a);
        int unsigned k;
        k = {16'd0, a};
        if (ref_mem.exists(k)) begin
            return ref_mem[k];
        end
        return init_word(a);
    endfunction

    // Drive one cycle, check grants and memory port against the model, then advance the model
    task automatic cycle(input bit r, input bit fr, input logic [31:0] fa,
                         input bit lr, input logic [31:0] la, input logic [31:0] ld,
                         output bit gf, output bit gl);
        bit   fbad;
        bit   lbad;
        bit   en;
        bit   we;
        rsp_t rsp;
        @(posedge clk);
        #1;
        rst        = r;
        fetch_req  = fr;
        fetch_addr = fa;
        load_req   = lr;
        load_addr  = la;
        load_data  = ld;
        if (r) exp_q.delete();
        fbad = (fa[31:16] != 16'd0);
        lbad = (la[31:16] != 16'd0);
        gl   = !r && lr && (!fr || waits >= STARVE_MAX);
        gf   = !r && fr && !gl;
        en   = (gl && !lbad) || (gf && !fbad);
        we   = gl && !lbad;
        @(negedge clk);
        check("fetch_gnt", 32'(fetch_gnt), 32'(gf));
        check("load_gnt", 32'(load_gnt), 32'(gl));
        check("mem_en", 32'(mem_en), 32'(en));
        check("mem_we", 32'(mem_we), 32'(we));
        if (en) check("mem_addr", 32'(mem_addr), gl ? {16'd0, la[15:0]} : {16'd0, fa[15:0]});
        if (we) check("mem_wdata", mem_wdata, ld);
        if (r) begin
            check("rst_mem_addr", 32'(mem_addr), 32'd0);
            check("rst_mem_wdata", mem_wdata, 32'd0);
        end
        check("addr_fault", 32'(addr_fault), r ? 32'd0 : 32'(fault_m));
        if (r) begin
            waits   = 0;
            fault_m = 1'b0;
        end else begin
            if (gl) waits = 0;
            else if (lr && waits < STARVE_MAX) waits++;
            if (gl && !lbad) ref_mem[{16'd0, la[15:0]}] = ld;
            if (gf) begin
                rsp.due   = cyc + 1;
                rsp.instr = fbad ? 32'h0 : ref_rd(fa[15:0]);
                exp_q.push_back(rsp);
            end
            if ((gf && fbad) || (gl && lbad)) fault_m = 1'b1;
        end
    endtask

    // Monitor: every cycle the fetch response must match the scoreboard head or be idle
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                check("rsp_valid", 32'(fetch_valid), 32'd1);
                check("rsp_instr", fetch_instr, exp_q[0].instr);
                void'(exp_q.pop_front());
            end else begin
                check("idle_valid", 32'(fetch_valid), 32'd0);
                check("idle_instr", fetch_instr, 32'd0);
            end
        end
    end

    initial begin
        bit          gf;
        bit          gl;
        bit          pf;
        bit          pl;
        bit          rr;
        logic [31:0] pfa;
        logic [31:0] pla;
        logic [31:0] pld;
        rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
        load_req = 1'b0; load_addr = '0; load_data = '0;
        pf = 1'b0; pl = 1'b0; pfa = '0; pla = '0; pld = '0;

        repeat (2) cycle(1, 0, 0, 0, 0, 0, gf, gl);
        repeat (3) cycle(0, 0, 0, 0, 0, 0, gf, gl);

        // Preload A,B,C then stream fetches 0,1,2
        cycle(0, 0, 0, 1, 32'd0, 32'hA0A0_0001, gf, gl);
        cycle(0, 0, 0, 1, 32'd1, 32'hB0B0_0002, gf, gl);
        cycle(0, 0, 0, 1, 32'd2, 32'hC0C0_0003, gf, gl);
        cycle(0, 1, 32'd0, 0, 0, 0, gf, gl);
        check("stream_gnt0", 32'(fetch_gnt), 32'd1);
        cycle(0, 1, 32'd1, 0, 0, 0, gf, gl);
        check("stream_gnt1", 32'(fetch_gnt), 32'd1);
        check("stream_A", fetch_instr, 32'hA0A0_0001);
        cycle(0, 1, 32'd2, 0, 0, 0, gf, gl);
        check("stream_gnt2", 32'(fetch_gnt), 32'd1);
        check("stream_B", fetch_instr, 32'hB0B0_0002);
        cycle(0, 0, 0, 0, 0, 0, gf, gl);
        check("stream_C", fetch_instr, 32'hC0C0_0003);

        // Both held: four fetch grants then the load, twice over
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 32'(8 + i), 1, 32'd9, 32'h1111_2222, gf, gl);
            check("starve_fetch", 32'(fetch_gnt), 32'((i % 5) != 4));
            check("starve_load", 32'(load_gnt), 32'((i % 5) == 4));
        end
        cycle(0, 0, 0, 0, 0, 0, gf, gl);

        // Read-after-write
        cycle(0, 0, 0, 1, 32'd5, 32'hDEAD_BEEF, gf, gl);
        cycle(0, 1, 32'd5, 0, 0, 0, gf, gl);
        cycle(0, 0, 0, 0, 0, 0, gf, gl);
        check("raw_instr", fetch_instr, 32'hDEAD_BEEF);

        // Reset right after a fetch grant discards the response
        cycle(0, 1, 32'd3, 0, 0, 0, gf, gl);
        cycle(1, 1, 32'd3, 0, 0, 0, gf, gl);
        check("rst_valid", 32'(fetch_valid), 32'd0);
        check("rst_gnt", 32'(fetch_gnt), 32'd0);
        check("rst_instr", fetch_instr, 32'd0);
        cycle(0, 0, 0, 0, 0, 0, gf, gl);
        check("post_rst_valid", 32'(fetch_valid), 32'd0);

        // Out-of-range fetch
        cycle(0, 1, 32'h0001_0000, 0, 0, 0, gf, gl);
        check("oor_gnt", 32'(fetch_gnt), 32'd1);
        check("oor_no_mem", 32'(mem_en), 32'd0);
        cycle(0, 0, 0, 0, 0, 0, gf, gl);
        check("oor_valid", 32'(fetch_valid), 32'd1);
        check("oor_noop", fetch_instr, 32'd0);
        check("oor_fault", 32'(addr_fault), 32'd1);
        repeat (3) cycle(0, 0, 0, 0, 0, 0, gf, gl);
        check("fault_sticky", 32'(addr_fault), 32'd1);

        // Random traffic; requesters hold until granted, occasionally drop or reset
        repeat (3000) begin
            if (!pf && $urandom_range(3) != 0) begin
                pf  = 1'b1;
                pfa = ($urandom_range(15) == 0) ? (32'h0001_0000 | $urandom) : 32'($urandom_range(15));
            end
            if (!pl && $urandom_range(3) == 0) begin
                pl  = 1'b1;
                pla = ($urandom_range(31) == 0) ? (32'h0100_0000 | $urandom) : 32'($urandom_range(15));
                pld = $urandom;
            end
            if (pf && $urandom_range(19) == 0) pf = 1'b0;
            rr = ($urandom_range(199) == 0);
            cycle(rr, pf, pfa, pl, pla, pld, gf, gl);
            if (gf) pf = 1'b0;
            if (gl) pl = 1'b0;
        end

        cycle(1, 0, 0, 0, 0, 0, gf, gl);
        cycle(0, 0, 0, 0, 0, 0, gf, gl);
        check("final_fault_clear", 32'(addr_fault), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
